uart_tx_cfg: RTL and testbench

Parametrised, runtime-configurable UART transmitter, the successor to the fixed-format TX block in the UART subsystem. Serialises one character per valid/ready handshake. Character length, parity mode and stop-bit count are set per frame. Bit timing comes from an external oversampling tick (s_tick) produced by the shared baud generator.

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_bit_timer.sv | 30 +++
 rtl/uart_tx_cfg.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter and its future RX sibling.
package uart_pkg;

  localparam int unsigned LEN_MIN = 5;
  localparam int unsigned LEN_W   = 4;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } tx_state_e;

  // Frame format captured at accept time
  typedef struct packed {
    parity_e          parity;
    logic             stop2;
    logic [LEN_W-1:0] len;
  } frame_cfg_t;

  // Mode 2'b11 is treated as no parity
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] len_max);
    if (len < LEN_W'(LEN_MIN)) return LEN_W'(LEN_MIN);
    if (len > len_max) return len_max;
    return len;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter: strobes bit_end_c on the OVS-th s_tick of each serial bit.
module uart_bit_timer #(
  parameter int unsigned OVS = 16
) (
  input  logic clk,
  input  logic Reset,
  input  logic en,
  input  logic clr,
  input  logic s_tick,
  output logic bit_end_c
);

  localparam int unsigned   TW        = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(OVS - 1);

  logic [TW-1:0] tcnt;

  assign bit_end_c = en & s_tick & (tcnt == TCNT_LAST);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      tcnt <= '0;
    end else if (clr || !en) begin
      tcnt <= '0;
    end else if (s_tick) begin
      tcnt <= (tcnt == TCNT_LAST) ? '0 : tcnt + TW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (length, parity, stop bits latched per frame).
// Optional line-break support is compiled in with UART_TX_BREAK_EN.
module uart_tx_cfg #(
  parameter int unsigned DATA_MAX = 9,
  parameter int unsigned OVS      = 16
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                s_tick,
  input  logic [DATA_MAX-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          cfg_len,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop2,
  input  logic                break_req,
  output logic                tx,
  output logic                tx_busy,
  output logic                tx_done_tick
);

  import uart_pkg::*;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_MAX);

  tx_state_e           state, state_nxt;
  logic [DATA_MAX-1:0] shift_q, shift_nxt;
  frame_cfg_t          cfg_q;
  logic                par_bit_q;
  logic [LEN_W-1:0]    bit_idx;
  logic                stop_half;
  logic                bit_end, timer_en, timer_clr, accept;
  logic                tx_nxt, busy_nxt, done_nxt;
  logic [LEN_W-1:0]    len_lat;
  logic                par_lat;

`ifdef UART_TX_BREAK_EN
  logic [1:0] brk_cnt;
  logic       brk_min_c;
  logic       brk_stop;

  assign in_ready  = (state == IDLE) & ~break_req & ~Reset;
  assign brk_min_c = (brk_cnt == 2'd2) | ((brk_cnt == 2'd1) & bit_end);
`else
  logic unused_break;

  assign in_ready     = (state == IDLE) & ~Reset;
  assign unused_break = break_req;
`endif

  assign accept    = in_valid & in_ready;
  assign timer_en  = (state != IDLE);
  assign timer_clr = (state_nxt != state);

  uart_bit_timer #(.OVS(OVS)) u_timer (
    .clk       (clk),
    .Reset     (Reset),
    .en        (timer_en),
    .clr       (timer_clr),
    .s_tick    (s_tick),
    .bit_end_c (bit_end)
  );

  // Length clamp and parity of the character being accepted
  always_comb begin
    len_lat = clamp_len(cfg_len, LEN_MAX);
    par_lat = 1'b0;
    for (int i = 0; i < int'(DATA_MAX); i++) begin
      if (LEN_W'(i) < len_lat) par_lat = par_lat ^ in_data[i];
    end
    if (decode_parity(cfg_parity) == PAR_ODD) par_lat = ~par_lat;
  end

  always_comb begin
    shift_nxt = shift_q;
    if (accept) shift_nxt = in_data;
    else if ((state == DATA) && bit_end) shift_nxt = shift_q >> 1;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_nxt;
      tx           <= tx_nxt;
      tx_busy      <= busy_nxt;
      tx_done_tick <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = START;
`ifdef UART_TX_BREAK_EN
        if (break_req) state_nxt = BREAK;
`endif
      end
      START:  if (bit_end) state_nxt = DATA;
      DATA: begin
        if (bit_end && (bit_idx == cfg_q.len - LEN_W'(1)))
          state_nxt = (cfg_q.parity != PAR_NONE) ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_nxt = STOP;
      STOP:   if (bit_end && (!cfg_q.stop2 || stop_half)) state_nxt = IDLE;
`ifdef UART_TX_BREAK_EN
      BREAK:  if (brk_min_c && !break_req) state_nxt = STOP;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Line level follows the state being entered so tx lines up with it
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:  tx_nxt = 1'b0;
      DATA:   tx_nxt = shift_nxt[0];
      PARITY: tx_nxt = par_bit_q;
`ifdef UART_TX_BREAK_EN
      BREAK:  tx_nxt = 1'b0;
`endif
      default: tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == STOP) && (state_nxt == IDLE);
`ifdef UART_TX_BREAK_EN
    done_nxt = done_nxt && !brk_stop;
`endif
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      shift_q   <= '0;
      cfg_q     <= '0;
      par_bit_q <= 1'b0;
      bit_idx   <= '0;
      stop_half <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt   <= '0;
      brk_stop  <= 1'b0;
`endif
    end else begin
      shift_q <= shift_nxt;
      if (accept) begin
        cfg_q.len    <= len_lat;
        cfg_q.parity <= decode_parity(cfg_parity);
        cfg_q.stop2  <= cfg_stop2;
        par_bit_q    <= par_lat;
        bit_idx      <= '0;
        stop_half    <= 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_stop     <= 1'b0;
`endif
      end else begin
        if ((state == DATA) && bit_end) bit_idx <= bit_idx + LEN_W'(1);
        if ((state == STOP) && bit_end) stop_half <= 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      // Break recovery uses a single stop bit and never reports a done
      if ((state == IDLE) && (state_nxt == BREAK)) begin
        brk_cnt     <= '0;
        brk_stop    <= 1'b1;
        stop_half   <= 1'b0;
        cfg_q.stop2 <= 1'b0;
      end else if ((state == BREAK) && bit_end && (brk_cnt != 2'd2)) begin
        brk_cnt <= brk_cnt + 2'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: random s_tick cadence against a slot-based frame model.
module tb_uart_tx_cfg;

  localparam int unsigned DATA_MAX = 9;
  localparam int unsigned OVS      = 16;
  localparam int          NR       = 8;

  logic       clk = 1'b0;
  logic       Reset, s_tick, in_valid, in_ready, cfg_stop2, break_req;
  logic       tx, tx_busy, tx_done_tick;
  logic [8:0] in_data;
  logic [3:0] cfg_len;
  logic [1:0] cfg_parity;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_pct = 100;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_MAX(DATA_MAX), .OVS(OVS)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .s_tick       (s_tick),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cfg_len      (cfg_len),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .break_req    (break_req),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int eff_len(input logic [3:0] l);
    int v;
    v = int'(l);
    if (v < 5) return 5;
    if (v > int'(DATA_MAX)) return int'(DATA_MAX);
    return v;
  endfunction

  function automatic bit par_on(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  function automatic int n_slots(input logic [3:0] l, input logic [1:0] p, input logic s);
    return 1 + eff_len(l) + (par_on(p) ? 1 : 0) + (s ? 2 : 1);
  endfunction

  // Expected line level during serial slot k of a frame
  function automatic logic exp_bit(input logic [8:0] d, input logic [3:0] l,
                                   input logic [1:0] p, input int k);
    int   len;
    logic x;
    len = eff_len(l);
    if (k == 0) return 1'b0;
    if (k <= len) return d[k-1];
    if (par_on(p) && (k == len + 1)) begin
      x = 1'b0;
      for (int i = 0; i < len; i++) x = x ^ d[i];
      return (p == 2'b10) ? ~x : x;
    end
    return 1'b1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic next_tick();
    s_tick = (int'($urandom_range(99)) < tick_pct);
  endtask

  task automatic drive_cfg(input logic [8:0] d, input logic [3:0] l,
                           input logic [1:0] p, input logic s);
    in_data = d; cfg_len = l; cfg_parity = p; cfg_stop2 = s;
  endtask

  task automatic start_frame(input logic [8:0] d, input logic [3:0] l, input logic [1:0] p,
                             input logic s, input string name);
    @(posedge clk); #1;
    in_valid = 1'b1;
    drive_cfg(d, l, p, s);
    next_tick();
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready: in_ready=%b expected 1", name, in_ready);
    end
  endtask

  // Follows one frame from its accept edge to the done cycle; the next inputs are applied
  // right after accept so that mid-frame changes and back-to-back chaining are exercised.
  task automatic run_frame(input logic [8:0] d, input logic [3:0] l, input logic [1:0] p,
                           input logic s, input logic nv, input logic [8:0] nd,
                           input logic [3:0] nl, input logic [1:0] np, input logic ns,
                           input string name);
    int   total, n, cyc, bad, first_bad;
    logic e;
    total = n_slots(l, p, s) * int'(OVS);
    n = 0; cyc = 0; bad = 0; first_bad = -1;
    @(posedge clk); #1;
    in_valid = nv;
    drive_cfg(nd, nl, np, ns);
    next_tick();
    while (cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (n >= total) break;
      e = exp_bit(d, l, p, n / int'(OVS));
      if (tx !== e || tx_busy !== 1'b1 || tx_done_tick !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = cyc;
      end
      if (s_tick) n++;
      @(posedge clk); #1;
      next_tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s bits: %0d bad cycles (first at cycle %0d) expected 0", name, bad, first_bad);
    end
    n_cmp++;
    if (n < total) begin
      n_bad++;
      $display("FAIL %s timeout: %0d of %0d ticks seen", name, n, total);
      return;
    end
    n_cmp++;
    if ({tx_done_tick, tx, tx_busy, in_ready} !== 4'b1101) begin
      n_bad++;
      $display("FAIL %s done: done/tx/busy/ready=%b%b%b%b expected 1101",
               name, tx_done_tick, tx, tx_busy, in_ready);
    end
    if (tick_pct == 100) begin
      n_cmp++;
      if (cyc != total + 1) begin
        n_bad++;
        $display("FAIL %s latency: done %0d cycles after first start cycle expected %0d",
                 name, cyc - 1, total);
      end
    end
    if (!nv) begin
      @(posedge clk); #1;
      next_tick();
      @(negedge clk);
      n_cmp++;
      if ({tx_done_tick, tx, tx_busy} !== 3'b010) begin
        n_bad++;
        $display("FAIL %s after_done: done/tx/busy=%b%b%b expected 010",
                 name, tx_done_tick, tx, tx_busy);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1; s_tick = 1'b1; in_valid = 1'b1; break_req = 1'b0;
    drive_cfg(9'h0FF, 4'd8, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx, tx_busy, tx_done_tick, in_ready} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_state: tx/busy/done/ready=%b%b%b%b expected 1000",
               tx, tx_busy, tx_done_tick, in_ready);
    end
    @(posedge clk); #1;
    Reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({tx, tx_busy, in_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL reset_release: tx/busy/ready=%b%b%b expected 101", tx, tx_busy, in_ready);
    end
  endtask

  task automatic test_frame_bits();
    tick_pct = 100;
    start_frame(9'h0A5, 4'd8, 2'b01, 1'b0, "frame_a5");
    run_frame(9'h0A5, 4'd8, 2'b01, 1'b0, 1'b0, 9'h000, 4'd8, 2'b00, 1'b0, "frame_a5");
  endtask

  task automatic test_parity_modes();
    tick_pct = 100;
    start_frame(9'h007, 4'd7, 2'b10, 1'b0, "par_odd");
    run_frame(9'h007, 4'd7, 2'b10, 1'b0, 1'b0, 9'h000, 4'd7, 2'b00, 1'b0, "par_odd");
    start_frame(9'h007, 4'd7, 2'b01, 1'b0, "par_even");
    run_frame(9'h007, 4'd7, 2'b01, 1'b0, 1'b0, 9'h000, 4'd7, 2'b00, 1'b0, "par_even");
    start_frame(9'h007, 4'd7, 2'b00, 1'b0, "par_none");
    run_frame(9'h007, 4'd7, 2'b00, 1'b0, 1'b0, 9'h000, 4'd7, 2'b00, 1'b0, "par_none");
    start_frame(9'h007, 4'd7, 2'b11, 1'b0, "par_11");
    run_frame(9'h007, 4'd7, 2'b11, 1'b0, 1'b0, 9'h000, 4'd7, 2'b00, 1'b0, "par_11");
  endtask

  task automatic test_back_to_back();
    tick_pct = 100;
    start_frame(9'h03C, 4'd8, 2'b00, 1'b1, "stop2");
    run_frame(9'h03C, 4'd8, 2'b00, 1'b1, 1'b1, 9'h155, 4'd9, 2'b10, 1'b0, "stop2");
    run_frame(9'h155, 4'd9, 2'b10, 1'b0, 1'b0, 9'h000, 4'd8, 2'b00, 1'b0, "b2b_second");
  endtask

  task automatic test_cfg_stability();
    tick_pct = 100;
    start_frame(9'h0C5, 4'd8, 2'b01, 1'b0, "cfg_old");
    run_frame(9'h0C5, 4'd8, 2'b01, 1'b0, 1'b1, 9'h1F3, 4'd5, 2'b10, 1'b0, "cfg_old");
    run_frame(9'h1F3, 4'd5, 2'b10, 1'b0, 1'b0, 9'h000, 4'd5, 2'b00, 1'b0, "cfg_new");
  endtask

  task automatic test_clamp();
    tick_pct = 70;
    start_frame(9'h1E9, 4'd2, 2'b01, 1'b0, "clamp_lo");
    run_frame(9'h1E9, 4'd2, 2'b01, 1'b0, 1'b0, 9'h000, 4'd8, 2'b00, 1'b0, "clamp_lo");
    start_frame(9'h16B, 4'd15, 2'b10, 1'b1, "clamp_hi");
    run_frame(9'h16B, 4'd15, 2'b10, 1'b1, 1'b0, 9'h000, 4'd8, 2'b00, 1'b0, "clamp_hi");
  endtask

  task automatic test_reset_midframe();
    int bad;
    tick_pct = 100;
    start_frame(9'h1B6, 4'd8, 2'b01, 1'b1, "rst_mid");
    @(posedge clk); #1;
    in_valid = 1'b0; s_tick = 1'b1;
    repeat (70) @(posedge clk);
    #3;
    n_cmp++;
    if ({tx, tx_busy} !== {exp_bit(9'h1B6, 4'd8, 2'b01, 4), 1'b1}) begin
      n_bad++;
      $display("FAIL rst_mid pre: tx/busy=%b%b expected %b1", tx, tx_busy,
               exp_bit(9'h1B6, 4'd8, 2'b01, 4));
    end
    Reset = 1'b1;
    #1;
    n_cmp++;
    if ({tx, tx_busy, tx_done_tick, in_ready} !== 4'b1000) begin
      n_bad++;
      $display("FAIL rst_mid abort: tx/busy/done/ready=%b%b%b%b expected 1000",
               tx, tx_busy, tx_done_tick, in_ready);
    end
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_done_tick !== 1'b0 || tx !== 1'b1) bad++;
    end
    @(posedge clk); #1;
    Reset = 1'b0;
    @(negedge clk);
    if (tx_done_tick !== 1'b0 || tx !== 1'b1) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL rst_mid hold: %0d cycles with done or tx low, expected 0", bad);
    end
    start_frame(9'h0D2, 4'd6, 2'b01, 1'b0, "rst_after");
    run_frame(9'h0D2, 4'd6, 2'b01, 1'b0, 1'b0, 9'h000, 4'd8, 2'b00, 1'b0, "rst_after");
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic break_run(input int hold, input string name);
    int low, bad, j;
    logic ex_tx, ex_rdy;
    low = (hold < 2 * int'(OVS)) ? 2 * int'(OVS) : hold;
    bad = 0;
    tick_pct = 100; s_tick = 1'b1;
    @(posedge clk); #1;
    break_req = 1'b1;
    for (int k = 0; k < low + int'(OVS) + 1; k++) begin
      @(posedge clk); #1;
      j = k + 1;
      if (j == hold) break_req = 1'b0;
      @(negedge clk);
      ex_tx  = (j > low);
      ex_rdy = (j > low + int'(OVS));
      if (tx !== ex_tx || in_ready !== ex_rdy || tx_done_tick !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s: %0d bad cycles expected 0", name, bad);
    end
  endtask

  task automatic test_break();
    break_run(50, "break_50");
    break_run(10, "break_10");
  endtask
`else
  task automatic test_break();
    int bad;
    bad = 0;
    tick_pct = 100;
    @(posedge clk); #1;
    break_req = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || in_ready !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL break_ignored idle: %0d bad cycles expected 0", bad);
    end
    start_frame(9'h05A, 4'd8, 2'b10, 1'b0, "break_ignored");
    run_frame(9'h05A, 4'd8, 2'b10, 1'b0, 1'b0, 9'h000, 4'd8, 2'b00, 1'b0, "break_ignored");
    break_req = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [8:0] rd[NR+1];
    logic [3:0] rl[NR+1];
    logic [1:0] rp[NR+1];
    logic       rs[NR+1];
    logic       rb[NR+1];
    for (int i = 0; i <= NR; i++) begin
      rd[i] = 9'($urandom);
      rl[i] = 4'($urandom_range(15));
      rp[i] = 2'($urandom_range(3));
      rs[i] = 1'($urandom_range(1));
      rb[i] = (i > 0) && (i < NR) && ($urandom_range(1) == 1);
    end
    for (int i = 0; i < NR; i++) begin
      tick_pct = 25 + int'($urandom_range(75));
      if (!rb[i]) start_frame(rd[i], rl[i], rp[i], rs[i], "rand");
      run_frame(rd[i], rl[i], rp[i], rs[i], rb[i+1], rd[i+1], rl[i+1], rp[i+1], rs[i+1], "rand");
    end
  endtask

  initial begin
    test_reset();
    test_frame_bits();
    test_parity_modes();
    test_back_to_back();
    test_cfg_stability();
    test_clamp();
    test_reset_midframe();
    test_break();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
